data_pipe_interconnect_s2m_a2: RTL and testbench

- Routes one upstream data_inf stream (s00) to NUM downstream data_inf masters.
- Parametrised successor of the single-skid S2M interconnect: skid depth is configurable (DEPTH-entry FIFO), and each beat can be unicast (index) or multicast (bitmask).
- A lazy side-band payload travels with every beat.
- Out-of-range or empty destinations are dropped and counted.
- Sits between a single producer and per-channel consumers in the data_interface layer.

---
 rtl/data_pipe_interconnect_s2m_a2_if.sv | 11 +
 rtl/data_pipe_interconnect_s2m_a2.sv | 178 +++++++++++++++++
 tb/tb_data_pipe_interconnect_s2m_a2.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_pipe_interconnect_s2m_a2_if.sv
// Valid/ready stream bundle used by the data_interface layer.
interface data_inf #(
    parameter int DSIZE = 8
) ();
    logic             valid;
    logic             ready;
    logic [DSIZE-1:0] data;

    modport master (output valid, output data, input ready);
    modport slaver (input valid, input data, output ready);
endinterface

// File: rtl/data_pipe_interconnect_s2m_a2.sv
// One upstream stream fanned out to NUM downstream streams through a DEPTH-entry
// FIFO; each beat is unicast (index) or multicast (mask), empty destinations dropped.
module data_pipe_interconnect_s2m_a2 #(
    parameter int DSIZE  = 8,
    parameter int NUM    = 8,
    parameter int NSIZE  = $clog2(NUM),
    parameter int LAZISE = 1,
    parameter int DEPTH  = 4,
    parameter int MCAST  = 0
) (
    input  logic                           clock,
    input  logic                           rst_n,
    input  logic                           clk_en,
    input  logic [NSIZE-1:0]               addr,
    input  logic [NUM-1:0]                 addr_mask,
    input  logic [LAZISE-1:0]              s00_lazy_data,
    output logic [NUM-1:0][LAZISE-1:0]     m00_lazy_data,
    output logic                           drop_pulse,
    output logic [15:0]                    drop_cnt,
    output logic [$clog2(DEPTH):0]         level,
    data_inf.slaver                        s00,
    data_inf.master                        m00 [NUM]
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        ISSUE   = 2'd1,
        PARTIAL = 2'd2
    } head_state_t;

    head_state_t       state_q, state_d;
    logic [NUM-1:0]    pending_q, pending_d;
    logic [DSIZE-1:0]  head_data_q, head_data_d;
    logic [LAZISE-1:0] head_lazy_q, head_lazy_d;
    logic [LW-1:0]     level_q, level_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic              ready_en_q, ready_en_d;
    logic              drop_pulse_q, drop_pulse_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;

    logic [DSIZE-1:0]  data_mem [DEPTH];
    logic [LAZISE-1:0] lazy_mem [DEPTH];
    logic [NUM-1:0]    dest_mem [DEPTH];

    logic              s_ready;
    logic              push;
    logic              store;
    logic              drop;
    logic              pop;
    logic              active;
    logic [NUM-1:0]    push_dest;
    logic [NUM-1:0]    m_valid;
    logic [NUM-1:0]    m_ready;
    logic [NUM-1:0]    acc;
    logic [AW-1:0]     next_idx;

    // Channel fan-out: every channel sees the head beat, valid only where still pending.
    for (genvar gi = 0; gi < NUM; gi++) begin : g_ch
        assign m00[gi].valid     = m_valid[gi];
        assign m00[gi].data      = head_data_q;
        assign m_ready[gi]       = m00[gi].ready;
        assign m00_lazy_data[gi] = head_lazy_q;
    end

    assign s00.ready  = s_ready;
    assign level      = level_q;
    assign drop_pulse = drop_pulse_q;
    assign drop_cnt   = drop_cnt_q;

    always_comb begin
        push_dest = '0;
        if (MCAST != 0) begin
            push_dest = addr_mask;
        end else if (int'(addr) < NUM) begin
            push_dest = NUM'(1) << addr;
        end
    end

    // Ready depends on occupancy only, so a same-cycle pop never frees a slot.
    assign s_ready  = clk_en & ready_en_q & (level_q < LW'(DEPTH));
    assign push     = s00.valid & s_ready;
    assign store    = push & (|push_dest);
    assign drop     = push & ~(|push_dest);
    assign active   = (state_q != EMPTY);
    assign m_valid  = active ? pending_q : '0;
    assign acc      = m_valid & m_ready & {NUM{clk_en}};
    assign pop      = active & clk_en & ((pending_q & ~acc) == '0);
    assign next_idx = rd_ptr_q + AW'(1);

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        head_data_d  = head_data_q;
        head_lazy_d  = head_lazy_q;
        level_d      = level_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        ready_en_d   = 1'b1;
        drop_pulse_d = drop_pulse_q;
        drop_cnt_d   = drop_cnt_q;

        if (clk_en) begin
            drop_pulse_d = drop;
            if (drop && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
            if (store) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            level_d = level_q + LW'(store) - LW'(pop);

            if (pop) begin
                rd_ptr_d = next_idx;
                if (level_q > LW'(1)) begin
                    state_d     = ISSUE;
                    pending_d   = dest_mem[next_idx];
                    head_data_d = data_mem[next_idx];
                    head_lazy_d = lazy_mem[next_idx];
                end else if (store) begin
                    // Buffer drains this cycle; the incoming beat becomes the head directly.
                    state_d     = ISSUE;
                    pending_d   = push_dest;
                    head_data_d = s00.data;
                    head_lazy_d = s00_lazy_data;
                end else begin
                    state_d   = EMPTY;
                    pending_d = '0;
                end
            end else if ((state_q == EMPTY) && store) begin
                state_d     = ISSUE;
                pending_d   = push_dest;
                head_data_d = s00.data;
                head_lazy_d = s00_lazy_data;
            end else if (active && (|acc)) begin
                state_d   = PARTIAL;
                pending_d = pending_q & ~acc;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            pending_q    <= '0;
            head_data_q  <= '0;
            head_lazy_q  <= '0;
            level_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            ready_en_q   <= 1'b0;
            drop_pulse_q <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            head_data_q  <= head_data_d;
            head_lazy_q  <= head_lazy_d;
            level_q      <= level_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ready_en_q   <= ready_en_d;
            drop_pulse_q <= drop_pulse_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    // Storage needs no reset: the pointers and level define which entries are live.
    always_ff @(posedge clock) begin
        if (store) begin
            data_mem[wr_ptr_q] <= s00.data;
            lazy_mem[wr_ptr_q] <= s00_lazy_data;
            dest_mem[wr_ptr_q] <= push_dest;
        end
    end
endmodule

// File: tb/tb_data_pipe_interconnect_s2m_a2.sv
// Scoreboard bench: unicast instance (NUM=6) and multicast instance (NUM=8).
module tb_data_pipe_interconnect_s2m_a2;
    localparam int NA = 6;
    localparam int NB = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n  = 1'b0;
    logic clk_en = 1'b1;

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- instance A: unicast ----------------
    logic [2:0]         a_addr = '0;
    logic [NA-1:0]      a_mask = '0;
    logic               a_lazy_in = 1'b0;
    logic [NA-1:0][0:0] a_lazy;
    logic               a_drop_pulse;
    logic [15:0]        a_drop_cnt;
    logic [2:0]         a_level;
    logic               a_s_valid = 1'b0;
    logic [7:0]         a_s_data = '0;
    logic               a_s_ready;
    logic [NA-1:0]      a_valid;
    logic [NA-1:0]      a_mready = '1;
    logic [7:0]         a_data [NA];

    data_inf #(.DSIZE(8)) a_s ();
    data_inf #(.DSIZE(8)) a_m [NA] ();

    assign a_s.valid = a_s_valid;
    assign a_s.data  = a_s_data;
    assign a_s_ready = a_s.ready;
    for (genvar gi = 0; gi < NA; gi++) begin : g_a
        assign a_valid[gi]    = a_m[gi].valid;
        assign a_data[gi]     = a_m[gi].data;
        assign a_m[gi].ready  = a_mready[gi];
    end

    data_pipe_interconnect_s2m_a2 #(
        .DSIZE(8), .NUM(NA), .NSIZE(3), .LAZISE(1), .DEPTH(4), .MCAST(0)
    ) u_a (
        .clock(clk), .rst_n(rst_n), .clk_en(clk_en),
        .addr(a_addr), .addr_mask(a_mask), .s00_lazy_data(a_lazy_in),
        .m00_lazy_data(a_lazy), .drop_pulse(a_drop_pulse), .drop_cnt(a_drop_cnt),
        .level(a_level), .s00(a_s), .m00(a_m)
    );

    // ---------------- instance B: multicast ----------------
    logic [2:0]         b_addr = '0;
    logic [NB-1:0]      b_mask = '0;
    logic               b_lazy_in = 1'b0;
    logic [NB-1:0][0:0] b_lazy;
    logic               b_drop_pulse;
    logic [15:0]        b_drop_cnt;
    logic [2:0]         b_level;
    logic               b_s_valid = 1'b0;
    logic [7:0]         b_s_data = '0;
    logic               b_s_ready;
    logic [NB-1:0]      b_valid;
    logic [NB-1:0]      b_mready = '1;
    logic [7:0]         b_data [NB];

    data_inf #(.DSIZE(8)) b_s ();
    data_inf #(.DSIZE(8)) b_m [NB] ();

    assign b_s.valid = b_s_valid;
    assign b_s.data  = b_s_data;
    assign b_s_ready = b_s.ready;
    for (genvar gi = 0; gi < NB; gi++) begin : g_b
        assign b_valid[gi]    = b_m[gi].valid;
        assign b_data[gi]     = b_m[gi].data;
        assign b_m[gi].ready  = b_mready[gi];
    end

    data_pipe_interconnect_s2m_a2 #(
        .DSIZE(8), .NUM(NB), .NSIZE(3), .LAZISE(1), .DEPTH(4), .MCAST(1)
    ) u_b (
        .clock(clk), .rst_n(rst_n), .clk_en(clk_en),
        .addr(b_addr), .addr_mask(b_mask), .s00_lazy_data(b_lazy_in),
        .m00_lazy_data(b_lazy), .drop_pulse(b_drop_pulse), .drop_cnt(b_drop_cnt),
        .level(b_level), .s00(b_s), .m00(b_m)
    );

    // ---------------- scoreboard ----------------
    logic [8:0] exp_a [NA][$];
    logic [8:0] exp_b [NB][$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : mon_a
        logic [8:0] e;
        if (rst_n && clk_en) begin
            for (int k = 0; k < NA; k++) begin
                if (a_valid[k] && a_mready[k]) begin
                    if (exp_a[k].size() == 0) begin
                        n_checks++;
                        $display("FAIL a_extra_beat ch%0d: got data %0h expected no beat", k, a_data[k]);
                    end else begin
                        e = exp_a[k].pop_front();
                        check($sformatf("a_beat_ch%0d", k), {23'd0, a_lazy[k], a_data[k]}, {23'd0, e});
                        $display("A ch%0d beat data=%0h lazy=%0d", k, a_data[k], a_lazy[k]);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin : mon_b
        logic [8:0] e;
        if (rst_n && clk_en) begin
            for (int k = 0; k < NB; k++) begin
                if (b_valid[k] && b_mready[k]) begin
                    if (exp_b[k].size() == 0) begin
                        n_checks++;
                        $display("FAIL b_extra_beat ch%0d: got data %0h expected no beat", k, b_data[k]);
                    end else begin
                        e = exp_b[k].pop_front();
                        check($sformatf("b_beat_ch%0d", k), {23'd0, b_lazy[k], b_data[k]}, {23'd0, e});
                        $display("B ch%0d beat data=%0h lazy=%0d", k, b_data[k], b_lazy[k]);
                    end
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic a_send(input logic [2:0] ad, input logic [7:0] d, input logic lz,
                          input logic [NA-1:0] exp_dest);
        a_s_valid = 1'b1; a_addr = ad; a_s_data = d; a_lazy_in = lz;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (a_s_ready) begin
                for (int k = 0; k < NA; k++)
                    if (exp_dest[k]) exp_a[k].push_back({lz, d});
                @(posedge clk); #1;
                a_s_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        n_checks++;
        $display("FAIL a_send_timeout: data %0h got no ready, required ready within 200 cycles", d);
        a_s_valid = 1'b0;
    endtask

    task automatic b_send(input logic [NB-1:0] m, input logic [7:0] d, input logic lz,
                          input logic [NB-1:0] exp_dest);
        b_s_valid = 1'b1; b_mask = m; b_s_data = d; b_lazy_in = lz;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (b_s_ready) begin
                for (int k = 0; k < NB; k++)
                    if (exp_dest[k]) exp_b[k].push_back({lz, d});
                @(posedge clk); #1;
                b_s_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        n_checks++;
        $display("FAIL b_send_timeout: data %0h got no ready, required ready within 200 cycles", d);
        b_s_valid = 1'b0;
    endtask

    localparam logic [NA-1:0] UNI [NA] = '{6'b000001, 6'b000010, 6'b000100,
                                          6'b001000, 6'b010000, 6'b100000};

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_s_ready", a_s_ready, 0);
        check("rst_a_valid", a_valid, 0);
        check("rst_a_level", a_level, 0);
        check("rst_a_drop_cnt", a_drop_cnt, 0);
        check("rst_a_drop_pulse", a_drop_pulse, 0);
        check("rst_a_data0", a_data[0], 0);
        check("rst_a_lazy", a_lazy, 0);
        check("rst_b_s_ready", b_s_ready, 0);
        check("rst_b_valid", b_valid, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_a_s_ready", a_s_ready, 1);

        // unicast stream, one beat per cycle
        for (int k = 0; k < NA; k++) begin
            a_send(3'(k), 8'h11 + 8'(k), 1'(k % 2), UNI[k]);
            check("uni_valid", a_valid, UNI[k]);
            check("uni_data", a_data[k], 8'h11 + 8'(k));
            check("uni_level", a_level, 1);
        end
        @(posedge clk); #1;
        check("uni_drained", a_level, 0);

        // backpressure on channel 2
        a_mready[2] = 1'b0;
        for (int i = 0; i < 4; i++) a_send(3'd2, 8'h20 + 8'(i), 1'b0, 6'b000100);
        check("bp_level_full", a_level, 4);
        a_s_valid = 1'b1; a_addr = 3'd2; a_s_data = 8'h24; a_lazy_in = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("bp_s_ready_low", a_s_ready, 0);
            check("bp_level_hold", a_level, 4);
            check("bp_head_data", a_data[2], 8'h20);
        end
        @(posedge clk); #1;
        a_mready[2] = 1'b1;
        @(negedge clk);
        check("bp_ready_before_pop", a_s_ready, 0);
        a_send(3'd2, 8'h24, 1'b0, 6'b000100);
        check("bp_level_after_first_push", a_level, 3);
        a_send(3'd2, 8'h25, 1'b0, 6'b000100);
        check("bp_level_steady", a_level, 3);
        repeat (3) @(posedge clk);
        #1;
        check("bp_drain_1_per_cycle", a_level, 0);

        // drops: out-of-range index
        a_send(3'd7, 8'h77, 1'b0, 6'b000000);
        check("drop7_pulse", a_drop_pulse, 1);
        check("drop7_cnt", a_drop_cnt, 1);
        check("drop7_valid", a_valid, 0);
        check("drop7_level", a_level, 0);
        @(posedge clk); #1;
        check("drop_pulse_clears", a_drop_pulse, 0);
        a_send(3'd6, 8'h66, 1'b0, 6'b000000);
        check("drop6_cnt", a_drop_cnt, 2);

        // clk_en freeze with a held head
        a_mready[1] = 1'b0;
        a_send(3'd1, 8'h51, 1'b1, 6'b000010);
        a_send(3'd4, 8'h54, 1'b0, 6'b010000);
        clk_en = 1'b0;
        a_mready[1] = 1'b1;
        a_s_valid = 1'b1; a_addr = 3'd5; a_s_data = 8'h55; a_lazy_in = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("gate_valid", a_valid, 6'b000010);
            check("gate_data", a_data[1], 8'h51);
            check("gate_level", a_level, 2);
            check("gate_s_ready", a_s_ready, 0);
        end
        @(posedge clk); #1;
        clk_en = 1'b1;
        a_send(3'd5, 8'h55, 1'b0, 6'b100000);
        repeat (4) @(posedge clk);
        #1;
        check("gate_drained", a_level, 0);

        // reset with three beats buffered
        a_mready[3] = 1'b0;
        for (int i = 0; i < 3; i++) a_send(3'd3, 8'h30 + 8'(i), 1'b0, 6'b000000);
        check("mid_level", a_level, 3);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_valid", a_valid, 0);
        check("mid_rst_level", a_level, 0);
        check("mid_rst_s_ready", a_s_ready, 0);
        check("mid_rst_drop_cnt", a_drop_cnt, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("mid_rel_s_ready", a_s_ready, 1);
        a_mready[3] = 1'b1;
        a_send(3'd3, 8'h3C, 1'b1, 6'b001000);
        check("fresh_valid", a_valid, 6'b001000);
        check("fresh_data", a_data[3], 8'h3C);
        check("fresh_lazy", a_lazy[3], 1);
        @(posedge clk); #1;
        check("fresh_drained", a_level, 0);

        // multicast with one slow channel
        b_mready = 8'b1111_1011;
        b_send(8'b0000_0101, 8'hA5, 1'b0, 8'b0000_0101);
        check("mc_valid_first", b_valid, 8'b0000_0101);
        check("mc_data", b_data[2], 8'hA5);
        repeat (3) begin
            @(posedge clk); #1;
            check("mc_valid_partial", b_valid, 8'b0000_0100);
            check("mc_level_hold", b_level, 1);
        end
        b_mready[2] = 1'b1;
        @(posedge clk); #1;
        check("mc_valid_done", b_valid, 0);
        check("mc_level_done", b_level, 0);
        b_send(8'b1001_0010, 8'h5A, 1'b1, 8'b1001_0010);
        check("mc2_valid", b_valid, 8'b1001_0010);
        @(posedge clk); #1;
        check("mc2_level", b_level, 0);

        // empty mask drop and saturation
        b_send(8'b0000_0000, 8'hEE, 1'b0, 8'b0000_0000);
        check("mc_drop_pulse", b_drop_pulse, 1);
        check("mc_drop_cnt", b_drop_cnt, 1);
        b_s_valid = 1'b1; b_mask = '0;
        repeat (65540) @(posedge clk);
        #1;
        check("drop_cnt_saturated", b_drop_cnt, 16'hFFFF);
        b_s_valid = 1'b0;

        repeat (5) @(posedge clk);
        #1;
        for (int k = 0; k < NA; k++) check($sformatf("a_q_empty_ch%0d", k), exp_a[k].size(), 0);
        for (int k = 0; k < NB; k++) check($sformatf("b_q_empty_ch%0d", k), exp_b[k].size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
